drop_engine: RTL and testbench
==============================

Name: drop_engine

Overview:
- Game-logic stage that directly feeds the VGA renderer.
- Owns the scene state machine, player lane, and six falling-block slots (lane plus top row).
- Presents them in the packed form the renderer consumes: blocks[11:0], pos_blocks[59:0], people[1:0], scene[1:0].
- Advances motion once per frame_tick, spawns blocks from an LFSR, detects player/block collision and counts dodged blocks.

Parameters:
- SPEED, 4: rows added to each active block per frame_tick (1..15).
- SPAWN_GAP, 20: frame_ticks between spawn attempts (>=1).
- LFSR_SEED, 16'hACE1: LFSR reset value, must be nonzero.

Ports:
- clk  in  1  work clock, same domain as renderer clk
- resetn  in  1  synchronous active-low reset
- frame_tick  in  1  single-cycle pulse, once per display frame
- btn_left  in  1  single-cycle pulse, debounced upstream
- btn_right  in  1  single-cycle pulse, debounced upstream
- btn_start  in  1  single-cycle pulse, debounced upstream
- blocks  out  12  slot i lane at [2i+1:2i]
- pos_blocks  out  60  slot i top row at [10i+9:10i]
- people  out  2  player lane 0..3
- scene  out  2  0=START, 1=RUN, 2=END (3 never driven)
- score  out  16  blocks retired since entering RUN, saturating at 16'hFFFF

Behaviour:
- Reset (resetn=0 sampled on clk):
  - scene=START, people=1, blocks=0, every pos slot=PARK_ROW (10'd960), score=0.
  - Spawn counter=0, LFSR=LFSR_SEED.
- All outputs are registered. No combinational path from inputs to outputs.
- LFSR: 16-bit Galois, taps 16,14,13,11. It advances every clk in every state, so user timing adds entropy.
- Slot i is active iff pos_i != PARK_ROW.
- START:
  - On btn_start: enter RUN.
  - Same cycle: all slots park, score=0, spawn counter=0, people=1.
- RUN, player movement:
  - btn_left: people-1, saturating at 0.
  - btn_right: people+1, saturating at 3.
  - Both in the same cycle: no move.
  - Movement is applied on the pulse cycle, independent of frame_tick.
- RUN, on frame_tick (one-cycle update):
  - Each active slot: pos += SPEED, computed 11-bit. If result >= 480, the slot parks and score += 1; several slots retiring on the same tick add their count.
  - Spawn counter increments. When it reaches SPAWN_GAP it clears, and the lowest-index slot that is free after this tick's retirements loads lane = LFSR[1:0], pos = 0.
  - If no slot is free, the spawn is skipped and the counter still clears.
- Collision: evaluated every cycle in RUN from registered state. A hit is any active slot with lane==people, pos+80 > 400 and pos < 480.
  - Hit registered: scene=END on the next clk. Total latency 1 cycle after the offending state appears.
  - If a hit and a frame_tick coincide, END wins. That tick's motion and score still commit; positions freeze afterwards.
- END:
  - Slots, people and score hold. Buttons other than btn_start are ignored.
  - btn_start returns to START. Slots park; score holds until the next RUN entry.
- btn_start in RUN is ignored.
- frame_tick outside RUN is ignored. The spawn counter holds.
- Reset asserted mid-RUN: all of the reset values above apply on that edge.

Optional Feature:
- Macro SPEEDUP_EN.
  - Defined: effective speed = min(SPEED + score[15:4], 15). It rises by one row/tick every 16 points. The 11-bit add still applies.
  - Undefined: effective speed = SPEED constant. No extra logic.

Decomposition:
- Package drops_pkg:
  - scene encodings SCENE_START/RUN/END
  - PARK_ROW=960, BLOCK_H=80, PEO_ROW=400, ROW_MAX=480, N_SLOTS=6, LANES=4
- Sub-module drop_lfsr (clk, resetn, seed param, q[15:0]): free-running Galois LFSR.
- Slot update, collision check and FSM stay in drop_engine, using a generate loop over slots.

Test Plan:
- Reset then idle 100 cycles -> scene=0, people=1, every pos=960, score=0; no change on frame_tick.
- btn_start, then 20 frame_ticks with SPAWN_GAP=20 -> slot0 pos=0 with lane=LFSR[1:0]; after 5 more ticks slot0 pos=20.
- In RUN: btn_left x3 -> people 0,0,0; btn_right x5 -> 1,2,3,3,3; left+right same cycle -> unchanged.
- Force block into player's lane (people=2, slot lane 2), tick until pos=324 (>320) -> scene=2 exactly one clk after that state registers; pos values stop changing.
- Block in another lane ticks from 476 to 480 -> slot parks at 960, score 0->1. Two slots retiring on the same tick -> score +2.
- All 6 slots active at spawn time -> no slot changes lane/pos, spawn counter clears. With SPEEDUP_EN and score=32 -> active pos advances 6 per tick.

Source files
------------

// File: rtl/drops_pkg.sv
// Shared types and constants for the falling-block game stage.
package drops_pkg;

    localparam int unsigned POS_W   = 10;
    localparam int unsigned LANE_W  = 2;
    localparam int unsigned SCORE_W = 16;
    localparam int unsigned LFSR_W  = 16;
    localparam int unsigned N_SLOTS = 6;
    localparam int unsigned LANES   = 4;

    localparam int unsigned BLOCK_H = 80;
    localparam int unsigned PEO_ROW = 400;
    localparam int unsigned ROW_MAX = 480;

    // Row value that marks a slot as unused; far below the visible area.
    localparam logic [POS_W-1:0] PARK_ROW = 10'd960;

    // Galois feedback mask for taps 16,14,13,11 in a right-shifting register.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        SCENE_START = 2'd0,
        SCENE_RUN   = 2'd1,
        SCENE_END   = 2'd2
    } scene_t;

    // Galois step: shift right and fold the dropped bit back onto the taps.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        return {1'b0, cur[LFSR_W-1:1]} ^ (cur[0] ? LFSR_TAPS : LFSR_W'(0));
    endfunction

endpackage

// File: rtl/drop_lfsr.sv
// Free-running 16-bit Galois LFSR; never stops so player timing adds entropy.
module drop_lfsr
    import drops_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              resetn,
    output logic [LFSR_W-1:0] q
);

    // Reload the seed on reset, otherwise advance one step every clock.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            q <= SEED;
        end else begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/drop_engine.sv
// Game-logic stage feeding the VGA renderer: scene FSM, player lane, six
// falling-block slots, spawning, collision and dodge scoring.
// Build option: define SPEEDUP_EN to let fall speed grow with the score.
module drop_engine
    import drops_pkg::*;
#(
    parameter int unsigned       SPEED     = 4,
    parameter int unsigned       SPAWN_GAP = 20,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       frame_tick,
    input  logic                       btn_left,
    input  logic                       btn_right,
    input  logic                       btn_start,
    output logic [LANE_W*N_SLOTS-1:0]  blocks,
    output logic [POS_W*N_SLOTS-1:0]   pos_blocks,
    output logic [LANE_W-1:0]          people,
    output logic [1:0]                 scene,
    output logic [SCORE_W-1:0]         score
);

    localparam int unsigned CNT_W = $clog2(SPAWN_GAP + 1);
    localparam int unsigned SUM_W = POS_W + 1;

    scene_t               scene_q;
    scene_t               scene_d;
    logic [LANE_W-1:0]    people_q;
    logic [LANE_W-1:0]    people_d;
    logic [SCORE_W-1:0]   score_q;
    logic [SCORE_W-1:0]   score_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;
    logic [LANE_W-1:0]    lane_q [N_SLOTS];
    logic [LANE_W-1:0]    lane_d [N_SLOTS];
    logic [POS_W-1:0]     pos_q  [N_SLOTS];
    logic [POS_W-1:0]     pos_d  [N_SLOTS];
    logic [POS_W-1:0]     moved_pos [N_SLOTS];

    logic [LFSR_W-1:0]    lfsr_q;
    logic                 unused_lfsr_bits;
    logic [3:0]           speed_eff;

    logic [N_SLOTS-1:0]   active;
    logic [N_SLOTS-1:0]   retire;
    logic [N_SLOTS-1:0]   hit;
    logic [N_SLOTS-1:0]   free_slot;
    logic [N_SLOTS-1:0]   spawn_sel;
    logic                 spawn_found;
    logic [2:0]           retire_cnt;
    logic                 any_hit;

    logic [CNT_W:0]       cnt_inc;
    logic                 spawn_due;
    logic [SCORE_W:0]     score_sum;

    drop_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .resetn (resetn),
        .q      (lfsr_q)
    );

    // Only the low bits pick a lane; the rest exist to lengthen the sequence.
    assign unused_lfsr_bits = ^lfsr_q[LFSR_W-1:LANE_W];

`ifdef SPEEDUP_EN
    logic [12:0] speed_sum;

    // Speed climbs one row per tick every 16 points, capped at 15.
    assign speed_sum = 13'(SPEED) + 13'(score_q[SCORE_W-1:4]);
    assign speed_eff = (speed_sum > 13'd15) ? 4'd15 : speed_sum[3:0];
`else
    assign speed_eff = 4'(SPEED);
`endif

    // Per-slot motion, retirement, collision and renderer packing.
    for (genvar i = 0; i < N_SLOTS; i++) begin : g_slot
        logic [SUM_W-1:0] sum;
        logic [SUM_W-1:0] bottom;

        assign active[i]    = (pos_q[i] != PARK_ROW);
        assign sum          = {1'b0, pos_q[i]} + SUM_W'(speed_eff);
        assign bottom       = {1'b0, pos_q[i]} + SUM_W'(BLOCK_H);
        assign retire[i]    = active[i] && (sum >= SUM_W'(ROW_MAX));
        assign moved_pos[i] = !active[i] ? pos_q[i]
                            : (retire[i] ? PARK_ROW : sum[POS_W-1:0]);
        assign free_slot[i] = !active[i] || retire[i];
        assign hit[i]       = active[i] && (lane_q[i] == people_q)
                           && (bottom > SUM_W'(PEO_ROW))
                           && (pos_q[i] < POS_W'(ROW_MAX));

        assign blocks[LANE_W*i +: LANE_W]    = lane_q[i];
        assign pos_blocks[POS_W*i +: POS_W]  = pos_q[i];
    end

    // Count this tick's retirements and pick the lowest slot free afterwards.
    always_comb begin
        retire_cnt  = '0;
        spawn_sel   = '0;
        spawn_found = 1'b0;
        for (int i = 0; i < N_SLOTS; i++) begin
            retire_cnt = retire_cnt + 3'(retire[i]);
            if (free_slot[i] && !spawn_found) begin
                spawn_sel[i] = 1'b1;
                spawn_found  = 1'b1;
            end
        end
    end

    assign any_hit   = (scene_q == SCENE_RUN) && (|hit);
    assign cnt_inc   = {1'b0, cnt_q} + (CNT_W+1)'(1);
    assign spawn_due = (cnt_inc == (CNT_W+1)'(SPAWN_GAP));
    assign score_sum = {1'b0, score_q} + (SCORE_W+1)'(retire_cnt);

    // Scene state register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            scene_q <= SCENE_START;
        end else begin
            scene_q <= scene_d;
        end
    end

    // Scene transitions; a registered hit ends the run on the next edge.
    always_comb begin
        scene_d = scene_q;
        case (scene_q)
            SCENE_START: if (btn_start) scene_d = SCENE_RUN;
            SCENE_RUN:   if (any_hit)   scene_d = SCENE_END;
            SCENE_END:   if (btn_start) scene_d = SCENE_START;
            default:     scene_d = SCENE_START;
        endcase
    end

    // Next values of player, score, spawn counter and slots per scene.
    always_comb begin
        people_d = people_q;
        score_d  = score_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < N_SLOTS; i++) begin
            lane_d[i] = lane_q[i];
            pos_d[i]  = pos_q[i];
        end

        case (scene_q)
            SCENE_START: begin
                if (btn_start) begin
                    for (int i = 0; i < N_SLOTS; i++) pos_d[i] = PARK_ROW;
                    score_d  = '0;
                    cnt_d    = '0;
                    people_d = LANE_W'(1);
                end
            end

            SCENE_RUN: begin
                if (btn_left && !btn_right && (people_q != '0)) begin
                    people_d = people_q - LANE_W'(1);
                end else if (btn_right && !btn_left
                             && (people_q != LANE_W'(LANES - 1))) begin
                    people_d = people_q + LANE_W'(1);
                end

                if (frame_tick) begin
                    for (int i = 0; i < N_SLOTS; i++) pos_d[i] = moved_pos[i];
                    score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
                    if (spawn_due) begin
                        cnt_d = '0;
                        for (int i = 0; i < N_SLOTS; i++) begin
                            if (spawn_sel[i]) begin
                                lane_d[i] = lfsr_q[LANE_W-1:0];
                                pos_d[i]  = '0;
                            end
                        end
                    end else begin
                        cnt_d = cnt_inc[CNT_W-1:0];
                    end
                end
            end

            SCENE_END: begin
                if (btn_start) begin
                    for (int i = 0; i < N_SLOTS; i++) pos_d[i] = PARK_ROW;
                end
            end

            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            people_q <= LANE_W'(1);
            score_q  <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < N_SLOTS; i++) begin
                lane_q[i] <= '0;
                pos_q[i]  <= PARK_ROW;
            end
        end else begin
            people_q <= people_d;
            score_q  <= score_d;
            cnt_q    <= cnt_d;
            for (int i = 0; i < N_SLOTS; i++) begin
                lane_q[i] <= lane_d[i];
                pos_q[i]  <= pos_d[i];
            end
        end
    end

    assign people = people_q;
    assign scene  = scene_q;
    assign score  = score_q;

endmodule

// File: tb/tb_drop_engine.sv
// Bench for drop_engine: two instances (normal spawn gap and gap=1) checked
// every cycle against a behavioural game model, plus directed scenarios.
module tb_drop_engine;

    logic        clk;
    logic        resetn;
    logic        frame_tick;
    logic        btn_left;
    logic        btn_right;
    logic        btn_start;

    logic [11:0] blocks_a,  blocks_b;
    logic [59:0] pos_a,     pos_b;
    logic [1:0]  people_a,  people_b;
    logic [1:0]  scene_a,   scene_b;
    logic [15:0] score_a,   score_b;

    int total;
    int bad;

    // Behavioural model state, index 0 = main instance, 1 = gap-1 instance.
    int m_scene  [2];
    int m_people [2];
    int m_score  [2];
    int m_cnt    [2];
    int m_lfsr   [2];
    int m_lane   [2][6];
    int m_pos    [2][6];
    int p_speed  [2];
    int p_gap    [2];

    typedef struct {
        logic l;
        logic r;
        int   exp_people;
    } mv_vec_t;

    mv_vec_t mv [9];

    drop_engine #(.SPEED(4), .SPAWN_GAP(20), .LFSR_SEED(16'hACE1)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .frame_tick (frame_tick),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_start  (btn_start),
        .blocks     (blocks_a),
        .pos_blocks (pos_a),
        .people     (people_a),
        .scene      (scene_a),
        .score      (score_a)
    );

    drop_engine #(.SPEED(4), .SPAWN_GAP(1), .LFSR_SEED(16'hACE1)) dut_f (
        .clk        (clk),
        .resetn     (resetn),
        .frame_tick (frame_tick),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_start  (btn_start),
        .blocks     (blocks_b),
        .pos_blocks (pos_b),
        .people     (people_b),
        .scene      (scene_b),
        .score      (score_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock of the game rules, applied to the model of instance k.
    task automatic model_step(input int k);
        int nl;
        int hit;
        int spd;
        int ret;
        int fr;
        nl = m_lfsr[k] >> 1;
        if ((m_lfsr[k] & 1) != 0) nl = nl ^ 'hB400;
        if (!resetn) begin
            m_scene[k] = 0; m_people[k] = 1; m_score[k] = 0; m_cnt[k] = 0;
            for (int i = 0; i < 6; i++) begin m_lane[k][i] = 0; m_pos[k][i] = 960; end
            m_lfsr[k] = 'hACE1;
            return;
        end
        hit = 0;
        if (m_scene[k] == 1)
            for (int i = 0; i < 6; i++)
                if (m_pos[k][i] != 960 && m_lane[k][i] == m_people[k]
                    && m_pos[k][i] + 80 > 400 && m_pos[k][i] < 480) hit = 1;
        if (m_scene[k] == 0) begin
            if (btn_start) begin
                m_scene[k] = 1; m_score[k] = 0; m_cnt[k] = 0; m_people[k] = 1;
                for (int i = 0; i < 6; i++) m_pos[k][i] = 960;
            end
        end else if (m_scene[k] == 1) begin
            if (btn_left && !btn_right && m_people[k] > 0) m_people[k]--;
            else if (btn_right && !btn_left && m_people[k] < 3) m_people[k]++;
            if (frame_tick) begin
                spd = p_speed[k];
`ifdef SPEEDUP_EN
                spd = spd + m_score[k] / 16;
                if (spd > 15) spd = 15;
`endif
                ret = 0;
                for (int i = 0; i < 6; i++) begin
                    if (m_pos[k][i] != 960) begin
                        m_pos[k][i] += spd;
                        if (m_pos[k][i] >= 480) begin m_pos[k][i] = 960; ret++; end
                    end
                end
                m_score[k] = (m_score[k] + ret > 65535) ? 65535 : m_score[k] + ret;
                m_cnt[k]++;
                if (m_cnt[k] == p_gap[k]) begin
                    m_cnt[k] = 0;
                    fr = -1;
                    for (int i = 5; i >= 0; i--) if (m_pos[k][i] == 960) fr = i;
                    if (fr >= 0) begin m_lane[k][fr] = m_lfsr[k] & 3; m_pos[k][fr] = 0; end
                end
            end
            if (hit != 0) m_scene[k] = 2;
        end else begin
            if (btn_start) begin
                m_scene[k] = 0;
                for (int i = 0; i < 6; i++) m_pos[k][i] = 960;
            end
        end
        m_lfsr[k] = nl;
    endtask

    task automatic model_pos(input int k, output logic [59:0] ep);
        for (int i = 0; i < 6; i++) ep[10*i +: 10] = 10'(m_pos[k][i]);
    endtask

    task automatic check_inst(input int k);
        logic [11:0] eb;
        logic [59:0] ep;
        logic [91:0] got, exp;
        for (int i = 0; i < 6; i++) eb[2*i +: 2] = 2'(m_lane[k][i]);
        model_pos(k, ep);
        exp = {eb, ep, 2'(m_people[k]), 2'(m_scene[k]), 16'(m_score[k])};
        got = (k == 0) ? {blocks_a, pos_a, people_a, scene_a, score_a}
                       : {blocks_b, pos_b, people_b, scene_b, score_b};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL model_inst%0d t=%0t got blocks=%h pos=%h people=%0d scene=%0d score=%0d exp blocks=%h pos=%h people=%0d scene=%0d score=%0d",
                     k, $time, got[91:80], got[79:20], got[19:18], got[17:16], got[15:0],
                     eb, ep, m_people[k], m_scene[k], m_score[k]);
        end
    endtask

    task automatic expect_val(input string name, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Drive one clock of inputs, advance both models, compare after the edge.
    task automatic cycle(input logic l, input logic r, input logic s, input logic t);
        btn_left = l; btn_right = r; btn_start = s; frame_tick = t;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        btn_left = 1'b0; btn_right = 1'b0; btn_start = 1'b0; frame_tick = 1'b0;
        check_inst(0);
        check_inst(1);
    endtask

    initial begin
        logic [59:0] snap;
        int target;
        int steps;
        int prev_score;
        int seen_retire;
        logic [3:0] danger;

        total = 0; bad = 0;
        p_speed[0] = 4; p_gap[0] = 20;
        p_speed[1] = 4; p_gap[1] = 1;
        resetn = 1'b0; btn_left = 1'b0; btn_right = 1'b0; btn_start = 1'b0; frame_tick = 1'b0;
        mv[0] = '{1'b1, 1'b0, 0}; mv[1] = '{1'b1, 1'b0, 0}; mv[2] = '{1'b1, 1'b0, 0};
        mv[3] = '{1'b0, 1'b1, 1}; mv[4] = '{1'b0, 1'b1, 2}; mv[5] = '{1'b0, 1'b1, 3};
        mv[6] = '{1'b0, 1'b1, 3}; mv[7] = '{1'b0, 1'b1, 3}; mv[8] = '{1'b1, 1'b1, 3};

        // Reset, then idle with frame ticks: nothing may move in START.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        resetn = 1'b1;
        for (int i = 0; i < 100; i++) cycle(1'b0, 1'b0, 1'b0, (i % 10) == 0);
        expect_val("idle_scene", scene_a, 0);
        expect_val("idle_people", people_a, 1);
        expect_val("idle_pos", pos_a, {6{10'd960}});
        expect_val("idle_score", score_a, 0);

        // Enter RUN and exercise lane movement.
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        expect_val("run_scene", scene_a, 1);
        for (int i = 0; i < 9; i++) begin
            cycle(mv[i].l, mv[i].r, 1'b0, 1'b0);
            expect_val($sformatf("move_%0d", i), people_a, mv[i].exp_people);
        end

        // Spawning: gap-1 instance fills all six slots, main spawns at tick 20.
        for (int t = 1; t <= 25; t++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b1);
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
            if (t == 7)
                expect_val("full_no_spawn", pos_b,
                           {10'd4, 10'd8, 10'd12, 10'd16, 10'd20, 10'd24});
            if (t == 20) begin
                expect_val("spawn_pos0", pos_a[9:0], 0);
                expect_val("spawn_lane0", blocks_a[1:0], m_lane[0][0]);
            end
        end
        expect_val("pos0_after5", pos_a[9:0], 20);

        // Collision: step into slot 0's lane and let it fall into the player.
        target = m_lane[0][0];
        steps = 0;
        while (m_people[0] != target && steps < 8) begin
            cycle(m_people[0] > target, m_people[0] < target, 1'b0, 1'b0);
            steps++;
        end
        expect_val("aligned_lane", people_a, target);
        steps = 0;
        while (m_pos[0][0] <= 320 && steps < 200) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b1);
            if (m_pos[0][0] <= 320) cycle(1'b0, 1'b0, 1'b0, 1'b0);
            steps++;
        end
        expect_val("hit_pos", pos_a[9:0], 324);
        expect_val("hit_scene_pre", scene_a, 1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        expect_val("hit_scene_end", scene_a, 2);
        model_pos(0, snap);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1);
        expect_val("end_frozen_pos", pos_a, snap);
        expect_val("end_scene_hold", scene_a, 2);

        // Restart and dodge until the first block retires.
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        expect_val("back_to_start", scene_a, 0);
        expect_val("start_parked", pos_a, {6{10'd960}});
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        expect_val("rerun_score", score_a, 0);
        seen_retire = 0;
        for (int t = 0; t < 400 && m_scene[0] == 1 && seen_retire == 0; t++) begin
            danger = '0;
            for (int i = 0; i < 6; i++)
                if (m_pos[0][i] != 960 && m_pos[0][i] + 30 > 320) danger[m_lane[0][i]] = 1'b1;
            if (danger[m_people[0]]) begin
                if (m_people[0] > 0 && !danger[m_people[0] - 1]) cycle(1'b1, 1'b0, 1'b0, 1'b0);
                else if (m_people[0] < 3 && !danger[m_people[0] + 1]) cycle(1'b0, 1'b1, 1'b0, 1'b0);
            end
            prev_score = m_score[0];
            cycle(1'b0, 1'b0, 1'b0, 1'b1);
            if (prev_score == 0 && m_score[0] > 0) begin
                seen_retire = 1;
                expect_val("first_retire_score", score_a, 1);
            end
        end

        // Randomised play, including occasional mid-game resets.
        for (int i = 0; i < 4000; i++) begin
            resetn = ($urandom_range(0, 499) != 0);
            cycle($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0);
        end
        resetn = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
